// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush controller for hazards that forwarding cannot
// resolve (load-use, branch-after-load in ID), data-memory freeze, and
// saturating stall/flush performance counters.
module hazard_stall_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             is_store_ID,
    input  logic             is_branch_ID,
    input  logic             branch_taken_ID,
    input  logic             jump_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             MemRead_MEM,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic ex_rs1;
    logic ex_rs2;
    logic mem_rs1;
    logic mem_rs2;
    logic lu;
    logic bl1;
    logic bl2;
    logic stall;
    logic xfer;

    // Dependence detection against the loads in EX and MEM; x0 never matches
    always_comb begin
        ex_rs1  = use_rs1_ID && (rd_EX  != 5'd0) && (rd_EX  == rs1_ID);
        ex_rs2  = use_rs2_ID && (rd_EX  != 5'd0) && (rd_EX  == rs2_ID);
        mem_rs1 = use_rs1_ID && (rd_MEM != 5'd0) && (rd_MEM == rs1_ID);
        mem_rs2 = use_rs2_ID && (rd_MEM != 5'd0) && (rd_MEM == rs2_ID);
        // Store data (rs2) is picked up later by WB-to-MEM forwarding
        lu      = !is_branch_ID && MemRead_EX  && (ex_rs1 || (ex_rs2 && !is_store_ID));
        bl2     =  is_branch_ID && MemRead_EX  && (ex_rs1 || ex_rs2);
        bl1     =  is_branch_ID && MemRead_MEM && (mem_rs1 || mem_rs2);
        // HOLD stalls on its own: the load has moved on to MEM by then
        stall   = (state == HOLD) || lu || bl1 || bl2;
        xfer    = (branch_taken_ID && is_branch_ID) || jump_ID;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and prioritized pipeline controls
    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_busy) begin
            // Whole pipeline holds; a pending HOLD survives the busy period
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else begin
            case (state)
                RUN:     state_nxt = bl2 ? HOLD : RUN;
                HOLD:    state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
            if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (xfer) begin
                ifid_flush  = 1'b1;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !mem_busy && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a cycle-by-cycle vector table plus
// hand sequences for reset-in-HOLD and counter saturation.
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic        use_rs1_ID;
    logic        use_rs2_ID;
    logic        is_store_ID;
    logic        is_branch_ID;
    logic        branch_taken_ID;
    logic        jump_ID;
    logic [4:0]  rd_EX;
    logic        MemRead_EX;
    logic [4:0]  rd_MEM;
    logic        MemRead_MEM;
    logic        mem_busy;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        s_pc_write;
    logic        s_ifid_write;
    logic        s_ifid_flush;
    logic        s_idex_bubble;
    logic        s_pipe_freeze;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit dut (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .is_store_ID(is_store_ID),
        .is_branch_ID(is_branch_ID), .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .rd_MEM(rd_MEM), .MemRead_MEM(MemRead_MEM),
        .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    hazard_stall_unit #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .is_store_ID(is_store_ID),
        .is_branch_ID(is_branch_ID), .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .rd_MEM(rd_MEM), .MemRead_MEM(MemRead_MEM),
        .mem_busy(mem_busy), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .pipe_freeze(s_pipe_freeze),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one ID cycle; ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       st;
        logic       br;
        logic       tk;
        logic       jp;
        logic [4:0] rdex;
        logic       mrex;
        logic [4:0] rdmem;
        logic       mrmem;
        logic       busy;
        logic [4:0] ctl;
        int         sc;
        int         fc;
    } vec_t;

    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11100;
    localparam logic [4:0] C_FRZ   = 5'b00001;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
        input logic st, input logic br, input logic tk, input logic jp,
        input logic [4:0] rdex, input logic mrex, input logic [4:0] rdmem, input logic mrmem,
        input logic busy, input logic [4:0] ctl, input int sc, input int fc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.st = st; v.br = br;
        v.tk = tk; v.jp = jp; v.rdex = rdex; v.mrex = mrex; v.rdmem = rdmem;
        v.mrmem = mrmem; v.busy = busy; v.ctl = ctl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs1_ID = v.rs1; rs2_ID = v.rs2; use_rs1_ID = v.u1; use_rs2_ID = v.u2;
        is_store_ID = v.st; is_branch_ID = v.br; branch_taken_ID = v.tk; jump_ID = v.jp;
        rd_EX = v.rdex; MemRead_EX = v.mrex; rd_MEM = v.rdmem; MemRead_MEM = v.mrmem;
        mem_busy = v.busy;
    endtask

    task automatic check_ctl(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ctl got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int sc, input int fc);
        checks++;
        if (stall_cnt !== 32'(sc) || flush_cnt !== 32'(fc)) begin
            errors++;
            $display("FAIL %s cnt got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, sc, fc);
        end
    endtask

    task automatic check_sat(input string name, input logic [2:0] exp);
        checks++;
        if (s_stall_cnt !== exp) begin
            errors++;
            $display("FAIL %s small stall_cnt got %0d want %0d", name, s_stall_cnt, exp);
        end
    endtask

    vec_t q;   // quiescent
    vec_t bl2v;
    vec_t luv;

    initial begin
        q    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);
        bl2v = mk(7, 0, 1, 1, 0, 1, 1, 0, 7, 1, 0, 0, 0, C_STALL, 0, 0);
        luv  = mk(5, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, C_STALL, 0, 0);

        //          rs1 rs2 u1 u2 st br tk jp rdex mrex rdmem mrmem busy ctl  sc fc
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0)); // quiet
        vecs.push_back(mk(5, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, C_STALL, 1, 0)); // load-use
        vecs.push_back(mk(5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, C_RUN,   1, 0)); // LU released
        vecs.push_back(mk(2, 5, 1, 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, C_RUN,   1, 0)); // store data exempt
        vecs.push_back(mk(7, 0, 1, 1, 0, 1, 1, 0, 7, 1, 0, 0, 0, C_STALL, 2, 0)); // BL2 run cycle
        vecs.push_back(mk(7, 0, 1, 1, 0, 1, 1, 0, 0, 0, 7, 1, 0, C_STALL, 3, 0)); // HOLD cycle
        vecs.push_back(mk(7, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, C_FLUSH, 3, 1)); // taken honoured
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 1)); // flush one cycle
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, C_RUN,   3, 1)); // x0 load in EX
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, C_RUN,   3, 1)); // x0 load in MEM
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_FLUSH, 3, 2)); // JAL
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 2)); // quiet
        vecs.push_back(mk(7, 0, 1, 0, 0, 1, 1, 0, 7, 1, 0, 0, 0, C_STALL, 4, 2)); // BL2, taken ignored
        vecs.push_back(mk(7, 0, 1, 0, 0, 1, 1, 0, 0, 0, 7, 1, 1, C_FRZ,   4, 2)); // busy 1 in HOLD
        vecs.push_back(mk(7, 0, 1, 0, 0, 1, 1, 0, 0, 0, 7, 1, 1, C_FRZ,   4, 2)); // busy 2
        vecs.push_back(mk(7, 0, 1, 0, 0, 1, 1, 0, 0, 0, 7, 1, 1, C_FRZ,   4, 2)); // busy 3
        vecs.push_back(mk(7, 0, 1, 0, 0, 1, 1, 0, 0, 0, 7, 1, 0, C_STALL, 5, 2)); // HOLD preserved
        vecs.push_back(mk(7, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, C_FLUSH, 5, 3)); // taken
        vecs.push_back(mk(5, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, C_FRZ,   5, 3)); // busy over LU
        vecs.push_back(mk(5, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, C_STALL, 6, 3)); // LU after busy
        vecs.push_back(mk(9, 0, 1, 0, 0, 1, 0, 0, 0, 0, 9, 1, 0, C_STALL, 7, 3)); // BL1 alone
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_FRZ,   7, 3)); // busy beats JAL
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_FLUSH, 7, 4)); // JAL after busy
        vecs.push_back(mk(0, 4, 0, 1, 0, 1, 0, 0, 4, 1, 0, 0, 1, C_FRZ,   7, 4)); // busy in BL2 run
        vecs.push_back(mk(0, 4, 0, 1, 0, 1, 0, 0, 4, 1, 0, 0, 0, C_STALL, 8, 4)); // BL2 via rs2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_STALL, 9, 4)); // HOLD alone stalls
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   9, 4)); // back to RUN
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, C_RUN,   9, 4)); // rs2 unused
        vecs.push_back(mk(5, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, C_RUN,   9, 4)); // ALU dep, no stall

        // Reset state
        drive(q);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_ctl("reset_ctl", C_RUN);
        check_cnt("reset_cnt", 0, 0);

        // Table: drive at negedge, check controls, then counters after the edge
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_ctl($sformatf("vec%0d", i), vecs[i].ctl);
            @(posedge clk);
            #1;
            check_cnt($sformatf("vec%0d", i), vecs[i].sc, vecs[i].fc);
        end
        check_sat("table_sat", 3'd7);

        // Reset pulsed while in HOLD: takes effect immediately
        @(negedge clk);
        drive(bl2v);
        @(posedge clk);
        #1;
        check_ctl("pre_rst_hold", C_STALL);
        drive(q);
        #1;
        rst = 1'b1;
        #1;
        check_cnt("rst_in_hold_cnt", 0, 0);
        check_ctl("rst_in_hold_ctl", C_RUN);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_ctl("after_rst_ctl", C_RUN);
        check_cnt("after_rst_cnt", 0, 0);

        // Forced stalls drive the narrow counter to all-ones and hold it there
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            drive(luv);
            @(posedge clk);
            #1;
            if (i >= 6) begin
                check_sat($sformatf("sat%0d", i), (i >= 7) ? 3'd7 : 3'(i));
            end
        end
        check_cnt("wide_after_sat", 9, 0);

        @(negedge clk);
        drive(q);
        @(posedge clk);
        #1;
        check_sat("sat_hold", 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and flush controller for the 5-stage pipeline, companion to the forwarding unit. Forwarding resolves every hazard it can reach by muxing data. This block handles the cases forwarding cannot reach: load-use, and branch-after-load in ID. For those it freezes PC and IF/ID, injects ID/EX bubbles, and flushes IF/ID on taken control transfers. It also freezes the whole pipeline while data memory is busy and keeps saturating stall/flush performance counters.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_ID, rs2_ID  in  5  source registers of instruction in ID
- use_rs1_ID, use_rs2_ID  in  1  instruction in ID actually reads rs1/rs2
- is_store_ID  in  1  ID instruction is a store (rs2 = store data only)
- is_branch_ID  in  1  ID instruction compares/uses operands in ID (Bxx, JALR)
- branch_taken_ID  in  1  ID branch/JALR resolved taken (meaningful only when not stalled)
- jump_ID  in  1  ID instruction is JAL
- rd_EX  in  5  destination of instruction in EX
- MemRead_EX  in  1  EX instruction is a load
- rd_MEM  in  5  destination of instruction in MEM
- MemRead_MEM  in  1  MEM instruction is a load
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP at next edge
- idex_bubble  out  1  load NOP into ID/EX at next edge
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  CNT_W  hazard-stall cycles since reset
- flush_cnt  out  CNT_W  flush cycles since reset

## Operation
- match_EX(r) = (rd_EX != 0) && (rd_EX == r). match_MEM(r) defined the same way on rd_MEM.
- LU (load-use) = !is_branch_ID && MemRead_EX && ((use_rs1_ID && match_EX(rs1_ID)) || (use_rs2_ID && !is_store_ID && match_EX(rs2_ID))).
  - Store-data-only dependence is exempt; it is covered by WB-to-MEM forwarding.
- BL2 = is_branch_ID && MemRead_EX && ((use_rs1_ID && match_EX(rs1_ID)) || (use_rs2_ID && match_EX(rs2_ID))).
- BL1 = is_branch_ID && MemRead_MEM && (same test on match_MEM).
- ALU-result dependences never stall; EX/MEM/WB-to-ID forwarding covers them.
- FSM states:
  - RUN: stall when LU, BL1 or BL2 is true. On BL2 go to HOLD at the next edge. Otherwise stay in RUN.
  - HOLD: unconditional second stall cycle for BL2. Go to RUN at the next edge.
- stall = (state == HOLD) || LU || BL1 || BL2.
- Priority, highest first:
  1. mem_busy: pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0. FSM state and counters hold.
  2. stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. Branch outcome is ignored.
  3. (branch_taken_ID && is_branch_ID) || jump_ID: ifid_flush=1, pc_write=1, ifid_write=1.
  4. Otherwise: pc_write=1, ifid_write=1, all other controls 0.
- stall_cnt increments on each edge where stall is true and mem_busy=0.
- flush_cnt increments on each edge where ifid_flush=1.
- Both counters saturate at all-ones and never wrap.
- Control outputs are combinational from state and inputs. Counters are registered.

## Timing
- Reset (async, any state, mid-stall included):
  - State goes to RUN and both counters go to 0.
  - With quiescent inputs the outputs settle to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
- LU costs exactly 1 stall cycle. BL1 costs exactly 1. BL2 costs exactly 2: RUN cycle plus HOLD cycle.
  - In the HOLD cycle the load has reached MEM. BL1 would also be true then; HOLD alone must already produce the stall.
- A taken branch is honoured only in the first cycle where it is not stalled. Flush lasts exactly 1 cycle per taken transfer.
- mem_busy for N cycles extends any stall by N cycles. A pending HOLD is preserved across the busy period.
- x0 destinations never cause a stall.

## Test plan
- lw x5 in EX, add x6,x5,x1 in ID -> one cycle with pc_write=0, idex_bubble=1; stall_cnt 0->1.
- lw x5 in EX, sw x5,0(x2) in ID (rs2 only, use_rs1 on x2) -> no stall, pc_write=1 throughout.
- lw x7 in EX, beq x7,x0 in ID taken -> 2 stall cycles (RUN then HOLD), then ifid_flush=1 for 1 cycle; stall_cnt=2, flush_cnt=1.
- lw x0 in EX, beq x0,x0 in ID -> no stall; JAL in ID -> ifid_flush=1 for exactly 1 cycle.
- BL2 detected, mem_busy=1 for 3 cycles starting in the HOLD cycle -> pipe_freeze=1 for 3 cycles, then 1 HOLD stall cycle; stall_cnt ends at 2.
- rst pulsed in HOLD -> RUN, counters 0 immediately. Separately, preload stall_cnt to all-ones via forced stalls -> it stays all-ones.
